// File: rtl/res_display.sv
// Shows an 8-bit unsigned result in decimal on a 4-digit multiplexed 7-segment display.
// A sequential double-dabble converter feeds a prescaled digit scanner.
`timescale 1ns/1ps
module res_display #(
  parameter int unsigned SCAN_DIV   = 50000,
  parameter int unsigned BLANK_LEAD = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  res,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic [11:0] bcd,
  output logic        busy,
  output logic [1:0]  state_o
);

  // Handshake: res is a level that is only sampled in IDLE. busy=1 means a
  // conversion is in flight and res changes are ignored; bcd is stable while busy=0.

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [19:0] sreg_q, sreg_d;
  logic [7:0]  cap_q, cap_d;
  logic [7:0]  last_val_q, last_val_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [11:0] bcd_q, bcd_d;
  logic        busy_q, busy_d;

  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    slot_q, slot_d;
  logic          scan_tick;
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    an_q, an_d;
  logic          hund_blank, tens_blank;

  // One double-dabble step: correct each BCD nibble that is >= 5, then shift.
  function automatic logic [19:0] dabble_step(input logic [19:0] s);
    logic [19:0] t;
    t = s;
    if (t[11:8]  >= 4'd5) t[11:8]  = t[11:8]  + 4'd3;
    if (t[15:12] >= 4'd5) t[15:12] = t[15:12] + 4'd3;
    if (t[19:16] >= 4'd5) t[19:16] = t[19:16] + 4'd3;
    return {t[18:0], 1'b0};
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  // Converter FSM: state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Converter FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (res != last_val_q) state_d = SHIFT;
      SHIFT:   if (cnt_q == 4'd7)     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Converter FSM: datapath and outputs
  always_comb begin
    sreg_d     = sreg_q;
    cap_d      = cap_q;
    cnt_d      = cnt_q;
    bcd_d      = bcd_q;
    last_val_d = last_val_q;
    case (state_q)
      IDLE: begin
        if (res != last_val_q) begin
          sreg_d = {12'b0, res};
          cap_d  = res;
          cnt_d  = 4'd0;
        end
      end
      SHIFT: begin
        sreg_d = dabble_step(sreg_q);
        cnt_d  = cnt_q + 4'd1;
      end
      DONE: begin
        bcd_d      = sreg_q[19:8];
        last_val_d = cap_q;
      end
      default: ;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sreg_q     <= '0;
      cap_q      <= '0;
      last_val_q <= '0;
      cnt_q      <= '0;
      bcd_q      <= '0;
      busy_q     <= 1'b0;
    end else begin
      sreg_q     <= sreg_d;
      cap_q      <= cap_d;
      last_val_q <= last_val_d;
      cnt_q      <= cnt_d;
      bcd_q      <= bcd_d;
      busy_q     <= busy_d;
    end
  end

  // Scanner: prescaler wraps at SCAN_DIV-1 and advances the digit slot.
  always_comb begin
    scan_tick = (presc_q == PRESC_LAST);
    presc_d   = scan_tick ? '0 : presc_q + PW'(1);
    slot_d    = scan_tick ? slot_q + 2'd1 : slot_q;
  end

  always_comb begin
    hund_blank = (BLANK_LEAD != 0) && (bcd_q[11:8] == 4'd0);
    tens_blank = (BLANK_LEAD != 0) && (bcd_q[11:4] == 8'd0);
    seg_d      = 7'h7F;
    an_d       = 4'hF;
    case (slot_q)
      2'd0: begin
        an_d  = 4'b1110;
        seg_d = seg7(bcd_q[3:0]);
      end
      2'd1: begin
        if (!tens_blank) begin
          an_d  = 4'b1101;
          seg_d = seg7(bcd_q[7:4]);
        end
      end
      2'd2: begin
        if (!hund_blank) begin
          an_d  = 4'b1011;
          seg_d = seg7(bcd_q[11:8]);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q <= '0;
      slot_q  <= 2'd0;
      seg_q   <= 7'h7F;
      an_q    <= 4'hF;
    end else begin
      presc_q <= presc_d;
      slot_q  <= slot_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
    end
  end

  assign seg     = seg_q;
  assign an      = an_q;
  assign bcd     = bcd_q;
  assign busy    = busy_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_res_display.sv
// Scoreboard bench for res_display: two instances (leading-zero blanking on/off)
// share the stimulus; expected BCD results queue up and are checked on busy fall.
`timescale 1ns/1ps
module tb_res_display;

  localparam int SD       = 4;
  localparam int MAX_WAIT = 300;
  localparam int BUSY_LEN = 9;

  // ---------------- clock / reset ----------------
  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] res   = 8'd0;

  always #5 clk = ~clk;

  logic [6:0]  seg_bl, seg_nb;
  logic [3:0]  an_bl, an_nb;
  logic [11:0] bcd_bl, bcd_nb;
  logic        busy_bl, busy_nb;
  logic [1:0]  st_bl, st_nb;

  res_display #(.SCAN_DIV(SD), .BLANK_LEAD(1)) u_bl (
    .clk(clk), .reset(reset), .res(res),
    .seg(seg_bl), .an(an_bl), .bcd(bcd_bl), .busy(busy_bl), .state_o(st_bl)
  );

  res_display #(.SCAN_DIV(SD), .BLANK_LEAD(0)) u_nb (
    .clk(clk), .reset(reset), .res(res),
    .seg(seg_nb), .an(an_nb), .bcd(bcd_nb), .busy(busy_nb), .state_o(st_nb)
  );

  // ---------------- reference model ----------------
  int          checks = 0;
  int          errors = 0;
  logic [11:0] exp_q[$];
  logic [7:0]  model_last = 8'd0;
  int          edge_cnt;
  logic [6:0]  seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Expected {an,seg} for a digit slot showing decimal value b (BCD).
  function automatic logic [10:0] disp_exp(input int slot, input logic [11:0] b, input bit blank);
    int h, t, o;
    h = int'(b[11:8]);
    t = int'(b[7:4]);
    o = int'(b[3:0]);
    case (slot)
      0: return {4'b1110, seg_tab[o]};
      1: return (blank && h == 0 && t == 0) ? {4'hF, 7'h7F} : {4'b1101, seg_tab[t]};
      2: return (blank && h == 0) ? {4'hF, 7'h7F} : {4'b1011, seg_tab[h]};
      default: return {4'hF, 7'h7F};
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) edge_cnt <= 0;
    else        edge_cnt <= edge_cnt + 1;
  end

  // ---------------- monitor / scoreboard ----------------
  logic        busy_prev = 1'b0;
  int          run       = 0;
  int          gap       = 0;
  bit          pending   = 1'b0;
  logic [11:0] disp      = 12'h000;

  always @(negedge clk) begin
    logic [10:0] e_bl, e_nb;
    logic [11:0] popped;
    if (!reset) begin
      check("rst_seg", 32'(seg_bl), 32'h7F);
      check("rst_an", 32'(an_bl), 32'hF);
      check("rst_bcd", 32'(bcd_bl), 32'h000);
      check("rst_busy", 32'(busy_bl), 32'h0);
      check("rst_disp_nb", {21'd0, an_nb, seg_nb}, {21'd0, 4'hF, 7'h7F});
      run     = 0;
      gap     = 0;
      pending = 1'b0;
      disp    = 12'h000;
    end else begin
      if (edge_cnt == 0) begin
        e_bl = {4'hF, 7'h7F};
        e_nb = {4'hF, 7'h7F};
      end else begin
        e_bl = disp_exp(((edge_cnt - 1) / SD) % 4, disp, 1'b1);
        e_nb = disp_exp(((edge_cnt - 1) / SD) % 4, disp, 1'b0);
      end
      check("disp_blank", {21'd0, an_bl, seg_bl}, {21'd0, e_bl});
      check("disp_noblank", {21'd0, an_nb, seg_nb}, {21'd0, e_nb});

      if (busy_bl && !busy_prev) begin
        check("busy_start_expected", 32'(exp_q.size() > 0), 32'd1);
        if (pending) check("idle_gap", 32'(gap), 32'd1);
        pending = 1'b0;
        run     = 1;
      end else if (busy_bl) begin
        run++;
      end else if (busy_prev) begin
        check("busy_len", 32'(run), 32'(BUSY_LEN));
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL bcd_unexpected: got %0h expected no conversion at %0t", bcd_bl, $time);
        end else begin
          popped = exp_q.pop_front();
          disp   = popped;
        end
        pending = (exp_q.size() > 0);
        gap     = 1;
      end else begin
        gap++;
      end
      check("bcd_value", 32'(bcd_bl), 32'(disp));
      check("bcd_value_nb", 32'(bcd_nb), 32'(disp));
    end
    busy_prev = busy_bl;
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply(input logic [7:0] v);
    res = v;
    if (v != model_last) begin
      exp_q.push_back(to_bcd(int'(v)));
      model_last = v;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy_bl !== 1'b0) && n < MAX_WAIT) begin
      tick(1);
      n++;
    end
    check("wait_idle_timeout", 32'(n < MAX_WAIT), 32'd1);
  endtask

  task automatic wait_room();
    int n;
    n = 0;
    while (exp_q.size() > 1 && n < MAX_WAIT) begin
      tick(1);
      n++;
    end
    check("wait_room_timeout", 32'(n < MAX_WAIT), 32'd1);
  endtask

  task automatic pulse_reset(input int cycles);
    reset = 1'b0;
    exp_q.delete();
    model_last = 8'd0;
    tick(cycles);
    reset = 1'b1;
    apply(res);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #1 reset = 1'b0;
    tick(3);
    reset = 1'b1;
    tick(6);

    apply(8'd1);
    wait_idle();
    tick(20);

    apply(8'd255);
    wait_idle();
    tick(20);

    apply(8'd100);
    wait_idle();
    tick(18);
    apply(8'd5);
    wait_idle();
    tick(18);

    apply(8'd42);
    tick(3);
    apply(8'd7);
    wait_idle();
    tick(18);

    apply(8'd42);
    tick(4);
    pulse_reset(2);
    wait_idle();
    tick(18);

    apply(8'd42);
    tick(5);

    for (int i = 0; i < 40; i++) begin
      logic [7:0] v;
      wait_room();
      v = ($urandom_range(0, 3) == 0) ? model_last : 8'($urandom_range(0, 255));
      apply(v);
      tick($urandom_range(1, 14));
    end
    wait_idle();
    tick(20);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
